// File: rtl/mem_max_scanner_pkg.sv
// Shared types and constants for the memory max-search engine.
package mem_max_scanner_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned MEM_DEC_W  = 16;

  localparam logic [31:0] MIN_SIGNED = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WR_MAX,
    S_WR_IDX,
    S_DONE
  } state_t;

endpackage

// File: rtl/mem_max_scanner_tracker.sv
// Signed running-maximum register pair with offset of the first occurrence.
module max_tracker #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_first,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  index,
  output logic [DATA_W-1:0] max_val,
  output logic [CNT_W-1:0]  max_idx,
  output logic [DATA_W-1:0] next_val
);

  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic [CNT_W-1:0] next_idx;

  // Strict compare keeps the lowest offset on ties.
  always_comb begin
    next_val = max_val;
    next_idx = max_idx;
    if (clear) begin
      next_val = MIN_VAL;
      next_idx = '0;
    end else if (valid && (load_first || ($signed(data) > $signed(max_val)))) begin
      next_val = data;
      next_idx = index;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_val <= MIN_VAL;
      max_idx <= '0;
    end else begin
      max_val <= next_val;
      max_idx <= next_idx;
    end
  end

endmodule

// File: rtl/mem_max_scanner.sv
// Streams a block of words from data memory, finds the signed maximum and
// writes value and offset back to dst_addr / dst_addr+1.
module mem_max_scanner
  import mem_max_scanner_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [CNT_W-1:0]  max_idx,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] WD,
  input  logic [DATA_W-1:0] RD
);

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  last_idx;
  logic [ADDR_W-1:0] dst_reg;
  logic [DATA_W-1:0] next_val;
  logic              clear;

  assign clear = (state == S_IDLE) && start && (count == '0);

  max_tracker #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_tracker (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .load_first(idx == '0),
    .valid     (state == S_SCAN),
    .data      (RD),
    .index     (idx),
    .max_val   (max_val),
    .max_idx   (max_idx),
    .next_val  (next_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      address  <= '0;
      WD       <= '0;
      idx      <= '0;
      last_idx <= '0;
      dst_reg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            dst_reg  <= dst_addr;
            idx      <= '0;
            last_idx <= count - CNT_W'(1);
            if (count != '0) begin
              state   <= S_SCAN;
              memRead <= 1'b1;
              address <= base_addr;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          // RD for this cycle's read is sampled on this edge, so the final
          // maximum is only visible through the tracker's next-state value.
          if (idx == last_idx) begin
            state    <= S_WR_MAX;
            memRead  <= 1'b0;
            memWrite <= 1'b1;
            address  <= dst_reg;
            WD       <= next_val;
          end else begin
            idx     <= idx + CNT_W'(1);
            address <= address + ADDR_W'(1);
          end
        end
        S_WR_MAX: begin
          state   <= S_WR_IDX;
          address <= dst_reg + ADDR_W'(1);
          WD      <= DATA_W'(max_idx);
        end
        S_WR_IDX: begin
          state    <= S_DONE;
          memWrite <= 1'b0;
          done     <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_max_scanner.sv
// Scoreboard bench for mem_max_scanner with a falling-edge data memory model.
module tb_mem_max_scanner;
  import mem_max_scanner_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] count = '0;
  logic [31:0] dst_addr = '0;
  logic        busy, done, memRead, memWrite;
  logic [31:0] max_val, address, WD;
  logic [15:0] max_idx;
  logic [31:0] RD = '0;

  logic [31:0] mem [0:65535];

  typedef struct {
    logic [31:0] val;
    logic [15:0] idx;
    int unsigned n;
    logic [31:0] dst;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  mem_max_scanner #(
    .DATA_W(32),
    .ADDR_W(32),
    .CNT_W (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .dst_addr (dst_addr),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .max_idx  (max_idx),
    .memRead  (memRead),
    .memWrite (memWrite),
    .address  (address),
    .WD       (WD),
    .RD       (RD)
  );

  always #5 clock = ~clock;

  // Memory acts on the falling edge and decodes the low 16 address bits.
  always @(negedge clock) begin
    if (memWrite) mem[address[15:0]] <= WD;
    if (memRead)  RD <= mem[address[15:0]];
  end

  task automatic load_image();
    logic [31:0] img [0:19];
    img = '{32'd100, -32'sd5, 32'd300, 32'd58000, 32'd7, 32'd12345, -32'sd99999,
            32'd58324, 32'd0, 32'd42, 32'd58324, -32'sd1, 32'd999, -32'sd40214,
            -32'sd19144, -32'sd26370, 32'd5000, 32'd58323, -32'sd7, 32'd1};
    for (int i = 0; i < 20; i++) mem[i] = img[i];
  endtask

  task automatic run(input logic [31:0] base, input logic [15:0] n, input logic [31:0] dst,
                     input logic [31:0] ev, input logic [15:0] ei, input int disturb,
                     input string name);
    exp_t e;
    int   k, rd, wr, exp_cyc;
    logic got_done;
    e.val = ev; e.idx = ei; e.n = n; e.dst = dst; e.name = name;
    exp_q.push_back(e);
    addr_log.delete();
    @(negedge clock);
    start = 1'b1; base_addr = base; count = n; dst_addr = dst;
    @(negedge clock);
    start = 1'b0; base_addr = 32'h5555; count = 16'd7; dst_addr = 32'h777;
    k = 1; rd = 0; wr = 0; got_done = 1'b0;
    while (k <= 200) begin
      if (k == disturb) begin
        start = 1'b1; base_addr = 32'h40; count = 16'd2;
      end else begin
        start = 1'b0;
      end
      if (memRead) begin rd++; addr_log.push_back(address); end
      if (memWrite) wr++;
      if (done) begin got_done = 1'b1; break; end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    exp_cyc = (e.n == 0) ? 1 : int'(e.n) + 3;
    checks++;
    if (got_done !== 1'b1) $display("FAIL %s.done_timeout: got no done, required done within 200 cycles", e.name);
    else passed++;
    checks++;
    if (k !== exp_cyc) $display("FAIL %s.done_cycle: got %0d required %0d", e.name, k, exp_cyc);
    else passed++;
    checks++;
    if (rd !== int'(e.n)) $display("FAIL %s.read_cycles: got %0d required %0d", e.name, rd, e.n);
    else passed++;
    checks++;
    if (wr !== ((e.n == 0) ? 0 : 2)) $display("FAIL %s.write_cycles: got %0d required %0d", e.name, wr, (e.n == 0) ? 0 : 2);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s.busy_at_done: got %b required 1", e.name, busy);
    else passed++;
    checks++;
    if (max_val !== e.val) $display("FAIL %s.max_val: got %h required %h", e.name, max_val, e.val);
    else passed++;
    checks++;
    if (max_idx !== e.idx) $display("FAIL %s.max_idx: got %0d required %0d", e.name, max_idx, e.idx);
    else passed++;
    if (e.n != 0) begin
      checks++;
      if (mem[e.dst[15:0]] !== e.val)
        $display("FAIL %s.mem_max: got %h required %h", e.name, mem[e.dst[15:0]], e.val);
      else passed++;
      checks++;
      if (mem[e.dst[15:0] + 16'd1] !== {16'd0, e.idx})
        $display("FAIL %s.mem_idx: got %h required %h", e.name, mem[e.dst[15:0] + 16'd1], {16'd0, e.idx});
      else passed++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset.ctrl: got busy=%b done=%b required 0 0", busy, done);
    else passed++;
    checks++;
    if (memRead !== 1'b0 || memWrite !== 1'b0) $display("FAIL reset.strobes: got rd=%b wr=%b required 0 0", memRead, memWrite);
    else passed++;
    checks++;
    if (address !== 32'd0 || WD !== 32'd0) $display("FAIL reset.bus: got addr=%h wd=%h required 0 0", address, WD);
    else passed++;
    checks++;
    if (max_val !== MIN_SIGNED || max_idx !== 16'd0) $display("FAIL reset.result: got %h/%0d required %h/0", max_val, max_idx, MIN_SIGNED);
    else passed++;
  endtask

  task automatic test_default();
    load_image();
    run(32'd0, 16'd20, 32'd100, 32'd58324, 16'd7, 0, "default");
  endtask

  task automatic test_negative();
    run(32'd13, 16'd3, 32'd120, 32'hFFFF_B538, 16'd1, 0, "negative");
  endtask

  task automatic test_ties_and_empty();
    mem[200] = 32'd5; mem[201] = 32'd9; mem[202] = 32'd9; mem[203] = 32'd2;
    run(32'd200, 16'd4, 32'd210, 32'd9, 16'd1, 0, "ties");
    run(32'd200, 16'd0, 32'd220, MIN_SIGNED, 16'd0, 0, "empty");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [0:3];
    exp_a = '{32'h0000_FFFE, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_0001};
    mem[16'hFFFE] = 32'd3; mem[16'hFFFF] = -32'sd8;
    run(32'h0000_FFFE, 16'd4, 32'd300, 32'd100, 16'd2, 0, "wrap");
    checks++;
    if (addr_log.size() !== 4) $display("FAIL wrap.addr_count: got %0d required 4", addr_log.size());
    else passed++;
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== exp_a[i]) $display("FAIL wrap.addr%0d: got %h required %h", i, addr_log[i], exp_a[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int wr;
    load_image();
    mem[100] = 32'hDEAD_BEEF; mem[101] = 32'h0000_1234;
    @(negedge clock);
    start = 1'b1; base_addr = 32'd0; count = 16'd20; dst_addr = 32'd100;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k < 5; k++) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (memRead !== 1'b0 || busy !== 1'b0) $display("FAIL abort.async_drop: got rd=%b busy=%b required 0 0", memRead, busy);
    else passed++;
    checks++;
    if (max_val !== MIN_SIGNED || address !== 32'd0) $display("FAIL abort.async_values: got %h/%h required %h/0", max_val, address, MIN_SIGNED);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    wr = 0;
    for (int k = 0; k < 30; k++) begin
      if (memWrite || done) wr++;
      @(negedge clock);
    end
    checks++;
    if (wr !== 0) $display("FAIL abort.no_activity: got %0d write/done cycles required 0", wr);
    else passed++;
    checks++;
    if (mem[100] !== 32'hDEAD_BEEF || mem[101] !== 32'h0000_1234)
      $display("FAIL abort.mem_kept: got %h/%h required deadbeef/00001234", mem[100], mem[101]);
    else passed++;
    run(32'd0, 16'd20, 32'd100, 32'd58324, 16'd7, 0, "after_abort");
  endtask

  task automatic test_ignored_start();
    run(32'd0, 16'd20, 32'd140, 32'd58324, 16'd7, 4, "ignored_start");
  endtask

  task automatic test_back_to_back();
    run(32'd13, 16'd3, 32'd160, 32'hFFFF_B538, 16'd1, 0, "b2b_first");
    run(32'd200, 16'd4, 32'd170, 32'd9, 16'd1, 0, "b2b_second");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_default();
    test_negative();
    test_ties_and_empty();
    test_wrap();
    test_reset_abort();
    test_ignored_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_max_scanner.md
# mem_max_scanner

Memory-initiator block that drives the data memory's `memRead`/`memWrite`/`address`/`WD` port and consumes its `RD` output. On a `start` pulse it streams `count` consecutive words from `base_addr` and tracks the signed maximum and its offset. It then writes the maximum and the offset back to `dst_addr` and `dst_addr+1`, and pulses `done`. It sits beside the CPU pipeline as a hardware max-search engine sharing the data memory port; the memory port is arbitrated outside this block.

## Interface
- `DATA_W`, default 32: word width of `RD`, `WD` and `max_val`.
- `ADDR_W`, default 32: width of `address`, `base_addr` and `dst_addr`.
- `CNT_W`, default 16: width of `count` and `max_idx`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; returns every register to its reset value immediately.
- `start` in 1: one-cycle request; sampled only while idle.
- `base_addr` in ADDR_W: first word address to scan; sampled with `start`.
- `count` in CNT_W: number of words to scan; sampled with `start`.
- `dst_addr` in ADDR_W: result write address; sampled with `start`.
- `busy` out 1: high from the cycle after `start` through the `done` cycle.
- `done` out 1: one-cycle completion pulse.
- `max_val` out DATA_W: signed maximum; holds its value until the next accepted `start`.
- `max_idx` out CNT_W: offset from `base_addr` of the maximum.
- `memRead` out 1: read strobe to the data memory.
- `memWrite` out 1: write strobe to the data memory.
- `address` out ADDR_W: memory address.
- `WD` out DATA_W: memory write data.
- `RD` in DATA_W: memory read data.

## Operation
- All outputs are registered. Reset values:
  - `busy`, `done`, `memRead`, `memWrite` = 0.
  - `address` = 0 and `WD` = 0.
  - `max_val` = 0x8000_0000 (most negative value).
  - `max_idx` = 0.
- States and transitions:
  - IDLE: `start` with `count` != 0 goes to SCAN. `start` with `count` == 0 goes to DONE with no memory access; `max_val` and `max_idx` are reset to their reset values.
  - SCAN: `memRead` = 1, `address` = `base_addr` + i for i = 0..count-1, one address per cycle. The last issue goes to WR_MAX.
  - WR_MAX: `memWrite` = 1, `address` = `dst_addr`, `WD` = `max_val`.
  - WR_IDX: `memWrite` = 1, `address` = `dst_addr` + 1, `WD` = `max_idx` zero-extended.
  - DONE: `done` = 1, `busy` = 1, then return to IDLE.
- Comparison rules:
  - Comparison is two's-complement signed.
  - The first element loads `max_val`/`max_idx` unconditionally.
  - Later elements update only when strictly greater, so ties keep the lowest offset.
- Address arithmetic is modulo 2^ADDR_W. The memory decodes `address[15:0]`, so a scan that crosses 0xFFFF wraps to word 0; this is legal and not flagged.
- A `dst_addr` range that overlaps the scan range is legal, because all reads complete before the first write.
- `start` while `busy` is ignored. `count`, `base_addr` and `dst_addr` are latched, so input changes during a run have no effect.
- `reset` mid-run aborts the run:
  - The block returns to IDLE.
  - `memRead`/`memWrite` drop asynchronously.
  - No partial result write occurs.

## Timing
- Memory handshake:
  - The memory acts on the falling edge.
  - A read issued in cycle k has `RD` stable by the rising edge that closes cycle k, and the scanner samples it there. No drain cycle is needed.
  - A write issued in cycle k commits at the falling edge of cycle k.
- Run schedule, with `start` sampled at rising edge 0:
  - SCAN occupies cycles 1..N.
  - WR_MAX is cycle N+1 and WR_IDX is cycle N+2.
  - `done` is high in cycle N+3.
  - Total latency is N+3 cycles; N = 0 gives `done` in cycle 1.
- `max_val`/`max_idx` are final from cycle N+1 and stable whenever `done` = 1.
- The earliest next `start` is accepted in cycle N+4.

## Structure
- The shared package holds:
  - The state enum (IDLE, SCAN, WR_MAX, WR_IDX, DONE).
  - `MIN_SIGNED` = 0x8000_0000.
  - Default widths matching the data memory (32-bit data, 16-bit decoded address).
- One natural sub-module is `max_tracker`: signed compare plus `max_val`/`max_idx` registers, with inputs load-first, valid, data and index. The FSM and address counter stay in the top.

## Test plan
- Default memory image (20 words at 0), `base_addr` = 0, `count` = 20, `dst_addr` = 100:
  - `max_val` = 58324 (0x0000E3D4) and `max_idx` = 7.
  - mem[100] = 58324 and mem[101] = 7.
  - `done` in cycle 23; `memRead` high for exactly 20 cycles.
- All-negative subrange, `base_addr` = 13, `count` = 3 (values -40214, -19144, -26370): `max_val` = 0xFFFFB538 (-19144) and `max_idx` = 1.
- Ties, memory preloaded {5, 9, 9, 2} at 200, `count` = 4: `max_idx` = 1. With `count` = 0: `done` in cycle 1, `memRead`/`memWrite` never asserted, `max_val` = 0x80000000.
- Wrap, `base_addr` = 0xFFFE, `count` = 4: addresses 0xFFFE, 0xFFFF, 0x10000, 0x10001 are issued, and words 0 and 1 are read via the low 16 bits.
- `reset` asserted in cycle 5 of a 20-word run:
  - Outputs go to reset values within the same cycle.
  - mem[100] and mem[101] are unchanged.
  - A new `start` after release completes normally.
- `start` pulsed again during SCAN and with `base_addr` changed: ignored; the original result and `done` timing are unchanged.
